shift_word_collector: RTL and testbench
=======================================

Name: shift_word_collector

Overview:
Downstream consumer of the universal shift register's serial output (s_left_dout / s_right_dout).
- Assembles the qualified serial bit stream into WIDTH-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface.
- Supports MSB-first or LSB-first assembly, forced flush of a partial word, and sticky overflow reporting.

Parameters:
WIDTH, 16, word width in bits (matches the shift register's parallel width)
DEPTH, 2, output FIFO entries; power of 2, minimum 2
CW, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
sin  in  1  serial data bit, sampled when sin_valid=1
sin_valid  in  1  qualifies sin for one clk
msb_first  in  1  1: first bit received lands in the highest filled position; 0: first bit lands in bit 0 of a full word
flush  in  1  pulse; emit the pending partial word
word_out  out  WIDTH  head-of-FIFO word
word_partial  out  1  head word was produced by flush (fewer than WIDTH bits)
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts the head word when word_valid=1
bit_count  out  CW  bits held in the accumulator, 0..WIDTH-1
overflow  out  1  sticky; a completed word was dropped

Behaviour:
- Reset (async assert, sync release): accumulator=0, bit_count=0, FIFO empty, word_out=0, word_partial=0, word_valid=0, overflow=0.
- Accumulate, per cycle with sin_valid=1:
  - msb_first=1: acc <= {acc[WIDTH-2:0], sin}.
  - msb_first=0: acc <= {sin, acc[WIDTH-1:1]}.
  - bit_count increments.
  - msb_first must be held stable within a word; changing it mid-word is undefined.
- Word completion: the bit that makes the count reach WIDTH pushes the full word with partial=0.
  - bit_count returns to 0 and the accumulator clears on that same edge.
  - word_valid is high after that edge, giving 1-cycle latency from the last bit to visibility.
- Flush: on flush=1 with bit_count>0 (count taken after any same-cycle bit), push the accumulator with partial=1, then clear the accumulator and count.
  - Resulting layout: MSB-first, n bits occupy [n-1:0], first bit at n-1; LSB-first, first bit at WIDTH-n; unused bits 0.
  - flush with bit_count=0 and no same-cycle bit: no push, no effect.
  - flush in the same cycle as the completing bit: the full word pushes with partial=0, flush has no further effect.
  - Same-cycle sin_valid and flush: the bit is included first, then the flush applies.
- FIFO:
  - Pop on word_valid & word_ready.
  - word_out and word_partial always show the head entry; both read 0 when empty.
  - Push while full with no same-cycle pop: the new word is dropped and overflow is set; overflow clears only on rst. FIFO contents are unchanged.
  - Push while full with a same-cycle pop: the push succeeds and overflow is not set.
  - Push while empty: visible next cycle; there is no combinational bypass.
- Pointers: log2(DEPTH)+1 bits with wrap-around; full/empty derived from the pointer MSB comparison.
- Reset mid-word or mid-transfer: all state is discarded immediately, with no partial emission.
- word_ready is ignored when word_valid=0.

Decomposition:
- Shared package shift_pkg: constants WORD_W=16, the default FIFO depth, and a typedef struct {logic [WORD_W-1:0] data; logic partial;} word_entry_t, also used by the upstream shift-register controller.
- One natural sub-module: sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty). It stores word_entry_t and exposes full so the collector can flag overflow.
- The collector body holds the accumulator, counter, flush logic, and overflow flag.

Test Plan:
- MSB-first word: msb_first=1, word_ready=1, 16 bits of 0xCCCC sent MSB first on consecutive cycles. Expect word_valid=1 the cycle after the 16th bit, word_out=0xCCCC, word_partial=0, bit_count=0.
- LSB-first word: msb_first=0, bits of 0x1234 sent LSB first. Expect word_out=0x1234; then send 0x1234 bits MSB first with msb_first=0. Expect word_out=0x2C48 (bit-reversed).
- Partial flush, MSB-first: bits 1,0,1,1 then a flush pulse. Expect word_out=0x000B, word_partial=1. Repeat LSB-first with the same bits. Expect word_out=0xD000, word_partial=1.
- Backpressure/overflow: word_ready=0, stream three full words A5A5, 5A5A, FFFF. Expect overflow=1 after the third word; raise word_ready and pop exactly A5A5 then 5A5A; overflow stays 1 until rst.
- Full-FIFO simultaneous push/pop: FIFO holds 2 words, word_ready=1 held on the cycle the next word completes. Expect no overflow; pop order is preserved across three words.
- Reset mid-word: 7 bits in, pulse rst asynchronously between edges. Expect bit_count=0, word_valid=0, overflow=0 immediately; the next 16 bits form a clean word with no residue.

Source files
------------

// File: rtl/shift_word_collector_pkg.sv
// Shared definitions for the shift-register datapath.
// The word width and default FIFO depth are used by the collector here and
// by the upstream shift-register controller. word_entry_t is one buffered
// word: its data bits plus a flag marking a flushed (short) word.
package shift_pkg;
    localparam int WORD_W     = 16;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              partial;
    } word_entry_t;
endpackage

// File: rtl/shift_word_collector_if.sv
// Bus between the serial-stream producer / word consumer and the collector.
//   sin, sin_valid  : qualified serial bit
//   msb_first       : assembly order for the current word
//   flush           : emit the pending partial word
//   word_out, word_partial, word_valid / word_ready : head-of-FIFO handshake
//   bit_count       : bits currently held in the accumulator
//   overflow        : sticky, a completed word was dropped
// slave  = collector side, master = producer/consumer side.
interface shift_word_collector_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             sin;
    logic             sin_valid;
    logic             msb_first;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_partial;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overflow;

    modport slave (
        input  sin, sin_valid, msb_first, flush, word_ready,
        output word_out, word_partial, word_valid, bit_count, overflow
    );

    modport master (
        output sin, sin_valid, msb_first, flush, word_ready,
        input  word_out, word_partial, word_valid, bit_count, overflow
    );
endinterface

// File: rtl/shift_word_collector_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i/din_i  : write request and data (ignored while full unless popping)
//   pop_i         : remove head entry (ignored while empty)
//   dout_o        : head entry, reads 0 when empty
//   full_o/empty_o: occupancy flags
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this same edge, so a push into a full FIFO may proceed.
    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through dout_o, masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/shift_word_collector.sv
// Collects a qualified serial bit stream into WIDTH-bit words and buffers
// them in a small FIFO presented on a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : shift_word_collector_if slave (serial input, flush, word
//              handshake, bit_count, sticky overflow)
// A word is pushed on the edge of its last bit (or on a flush) and becomes
// visible on the FIFO head one cycle later.
module shift_word_collector
    import shift_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_word_collector_if.slave   bus
);
    logic [WIDTH-1:0] acc_q, acc_d, acc_sh;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d;
    logic             complete, push, pop;
    logic             fifo_full, fifo_empty;
    logic [WIDTH:0]   fifo_din, fifo_dout;

    always_comb begin
        acc_sh = acc_q;
        if (bus.sin_valid)
            acc_sh = bus.msb_first ? {acc_q[WIDTH-2:0], bus.sin}
                                   : {bus.sin, acc_q[WIDTH-1:1]};
    end

    // Count includes a same-cycle bit, so flush sees it and completion is exact.
    assign cnt_inc  = cnt_q + CW'(bus.sin_valid);
    assign complete = (cnt_inc == CW'(WIDTH));
    // A completing bit takes precedence; a coincident flush then has nothing left.
    assign push     = complete | (bus.flush & (cnt_inc != '0));
    assign pop      = ~fifo_empty & bus.word_ready;

    // The shifted accumulator already holds the flushed layout: MSB-first
    // leaves n bits in [n-1:0], LSB-first leaves the first bit at WIDTH-n.
    assign fifo_din = {~complete, acc_sh};

    always_comb begin
        acc_d = push ? '0 : acc_sh;
        cnt_d = push ? '0 : cnt_inc;
        ovf_d = ovf_q | (push & fifo_full & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.word_out     = fifo_dout[WIDTH-1:0];
    assign bus.word_partial = fifo_dout[WIDTH];
    assign bus.word_valid   = ~fifo_empty;
    assign bus.bit_count    = cnt_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_shift_word_collector.sv
// Directed bench for shift_word_collector with a queue-based reference model
// checked every falling edge, plus literal expectations at key points.
module tb_shift_word_collector;
    import shift_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_word_collector_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    shift_word_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: received bits in arrival order, queue of buffered words.
    bit          m_bits[$];
    word_entry_t m_q[$];
    bit          m_ovf;
    bit          m_pop, m_push;
    word_entry_t m_new;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bits.delete();
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = (m_q.size() > 0) && bus.word_ready;
            m_push = 1'b0;
            if (bus.sin_valid) m_bits.push_back(bus.sin);
            if (m_bits.size() == WIDTH || (bus.flush && m_bits.size() > 0)) begin
                m_new.data    = '0;
                m_new.partial = (m_bits.size() != WIDTH);
                for (int i = 0; i < m_bits.size(); i++) begin
                    if (bus.msb_first)
                        m_new.data = m_new.data | (16'(m_bits[i]) << (m_bits.size() - 1 - i));
                    else
                        m_new.data = m_new.data | (16'(m_bits[i]) << (WIDTH - m_bits.size() + i));
                end
                m_push = 1'b1;
                m_bits.delete();
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_new);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_valid", 32'(bus.word_valid), 32'(m_q.size() > 0));
            chk("mdl_word", 32'(bus.word_out), (m_q.size() > 0) ? 32'(m_q[0].data) : 32'h0);
            chk("mdl_partial", 32'(bus.word_partial), (m_q.size() > 0) ? 32'(m_q[0].partial) : 32'h0);
            chk("mdl_count", 32'(bus.bit_count), 32'(m_bits.size()));
            chk("mdl_ovf", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic send(input logic [15:0] v, input int n, input bit msb_order);
        for (int i = 0; i < n; i++) begin
            bus.sin       = msb_order ? v[n-1-i] : v[i];
            bus.sin_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.sin = 0; bus.sin_valid = 0; bus.msb_first = 1; bus.flush = 0; bus.word_ready = 0;
        #1;
        chk("rst_valid", 32'(bus.word_valid), 0);
        chk("rst_word", 32'(bus.word_out), 0);
        chk("rst_partial", 32'(bus.word_partial), 0);
        chk("rst_count", 32'(bus.bit_count), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MSB-first full word
        bus.word_ready = 1;
        send(16'hCCCC, 16, 1);
        chk("msb_valid", 32'(bus.word_valid), 1);
        chk("msb_word", 32'(bus.word_out), 32'hCCCC);
        chk("msb_partial", 32'(bus.word_partial), 0);
        chk("msb_count", 32'(bus.bit_count), 0);
        idle(1);

        // LSB-first: natural order, then reversed order
        bus.msb_first = 0;
        send(16'h1234, 16, 0);
        chk("lsb_word", 32'(bus.word_out), 32'h1234);
        idle(1);
        send(16'h1234, 16, 1);
        chk("lsb_rev_word", 32'(bus.word_out), 32'h2C48);
        idle(1);

        // Partial flushes with bits 1,0,1,1
        bus.msb_first = 1;
        send(16'h000B, 4, 1);
        chk("part_msb_count", 32'(bus.bit_count), 4);
        do_flush();
        chk("part_msb_word", 32'(bus.word_out), 32'h000B);
        chk("part_msb_partial", 32'(bus.word_partial), 1);
        idle(1);
        do_flush();
        chk("empty_flush_valid", 32'(bus.word_valid), 0);
        bus.msb_first = 0;
        send(16'h000B, 4, 1);
        do_flush();
        chk("part_lsb_word", 32'(bus.word_out), 32'hD000);
        chk("part_lsb_partial", 32'(bus.word_partial), 1);
        idle(1);

        // Backpressure and overflow
        bus.msb_first  = 1;
        bus.word_ready = 0;
        send(16'hA5A5, 16, 1);
        send(16'h5A5A, 16, 1);
        send(16'hFFFF, 16, 1);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_head0", 32'(bus.word_out), 32'hA5A5);
        bus.word_ready = 1;
        idle(1);
        chk("ovf_head1", 32'(bus.word_out), 32'h5A5A);
        idle(1);
        chk("ovf_drained", 32'(bus.word_valid), 0);
        chk("ovf_sticky", 32'(bus.overflow), 1);
        rst = 1; #1;
        chk("ovf_cleared", 32'(bus.overflow), 0);
        rst = 0;
        idle(1);

        // Full FIFO with simultaneous push and pop
        bus.word_ready = 0;
        send(16'h1111, 16, 1);
        send(16'h2222, 16, 1);
        send(16'h3333 >> 1, 15, 1);
        bus.word_ready = 1;
        send(16'h0001, 1, 1);
        chk("pp_ovf", 32'(bus.overflow), 0);
        chk("pp_head0", 32'(bus.word_out), 32'h2222);
        idle(1);
        chk("pp_head1", 32'(bus.word_out), 32'h3333);
        idle(1);
        chk("pp_empty", 32'(bus.word_valid), 0);

        // Reset mid-word
        send(16'h0055, 7, 1);
        chk("mid_count", 32'(bus.bit_count), 7);
        #2 rst = 1; #1;
        chk("mid_rst_count", 32'(bus.bit_count), 0);
        chk("mid_rst_valid", 32'(bus.word_valid), 0);
        chk("mid_rst_ovf", 32'(bus.overflow), 0);
        rst = 0;
        send(16'h8001, 16, 1);
        chk("mid_clean_word", 32'(bus.word_out), 32'h8001);
        chk("mid_clean_partial", 32'(bus.word_partial), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
